// File: rtl/em_waitstate_ram.sv
// Byte-addressed little-endian RAM: wait-stated data port with range checking,
// plus a combinational halfword fetch port that forwards the committing write.
module em_waitstate_ram #(
  parameter int unsigned MEM_SIZE      = 125,
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned WAIT_STATES   = 1,
  parameter logic [15:0] ILLEGAL_INSTR = 16'he800
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [15:0]       i_data,
  output logic              busy
);

  // state   | meaning
  // IDLE    | ready; accepts a request with non-zero size
  // WAIT    | counting down programmed wait states
  // DONE    | ack/err/rdata valid; a clean write commits at the closing edge
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam int unsigned AW1   = ADDR_W + 1;
  localparam int unsigned IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [AW1-1:0] MEM_END = AW1'(MEM_SIZE);
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  function automatic logic [2:0] nbytes(input logic [1:0] sz);
    case (sz)
      2'd1:    nbytes = 3'd1;
      2'd2:    nbytes = 3'd2;
      2'd3:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  endfunction

  // Only called for in-range bytes, so truncating to the array index is safe.
  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a, input int i);
    logic [AW1-1:0] s;
    s = {1'b0, a} + AW1'(i);
    idx_of = s[IDX_W-1:0];
  endfunction

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic               we_q;
  logic [1:0]         size_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic               ack_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [7:0]         mem_q [0:MEM_SIZE-1];

  logic [ADDR_W-1:0]  cur_addr;
  logic [1:0]         cur_size;
  logic [2:0]         cur_n;
  logic [AW1-1:0]     cur_end;
  logic               cur_err;
  logic [31:0]        cur_rdata;

  // Access descriptor seen at the edge entering DONE: live inputs when
  // WAIT is skipped, the latched request otherwise.
  always_comb begin
    cur_addr  = (state_q == ST_IDLE) ? d_addr : addr_q;
    cur_size  = (state_q == ST_IDLE) ? d_size : size_q;
    cur_n     = nbytes(cur_size);
    cur_end   = {1'b0, cur_addr} + AW1'(cur_n) - AW1'(1);
    cur_err   = (cur_end >= MEM_END);
    cur_rdata = '0;
    if (!cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(cur_n)) cur_rdata[8*i +: 8] = mem_q[idx_of(cur_addr, i)];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (d_req && (d_size != 2'd0)) begin
            we_q    <= d_we;
            size_q  <= d_size;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            cnt_q   <= CNT_LOAD;
            if (WAIT_STATES == 0) begin
              state_q <= ST_DONE;
              ack_q   <= 1'b1;
              err_q   <= cur_err;
              rdata_q <= d_we ? 32'd0 : cur_rdata;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_DONE;
            ack_q   <= 1'b1;
            err_q   <= cur_err;
            rdata_q <= we_q ? 32'd0 : cur_rdata;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Contents survive reset; an async reset forces IDLE so a dropped write never lands.
  always_ff @(posedge clock) begin
    if ((state_q == ST_DONE) && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (i < int'(nbytes(size_q))) mem_q[idx_of(addr_q, i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  logic [AW1-1:0] fetch_base;
  logic           fetch_oob;
  logic           fwd_en;
  logic [2:0]     fwd_n;
  logic [AW1-1:0] fa;
  logic [AW1-1:0] off;
  logic [7:0]     byte_v;

  always_comb begin
    fetch_base = {1'b0, i_addr};
    fetch_oob  = ((fetch_base + AW1'(1)) >= MEM_END);
    fwd_en     = (state_q == ST_DONE) && we_q && !err_q;
    fwd_n      = nbytes(size_q);
    fa         = '0;
    off        = '0;
    byte_v     = '0;
    i_data     = ILLEGAL_INSTR;
    if (!fetch_oob) begin
      for (int j = 0; j < 2; j++) begin
        fa     = fetch_base + AW1'(j);
        off    = fa - {1'b0, addr_q};
        byte_v = mem_q[idx_of(i_addr, j)];
        if (fwd_en && (fa >= {1'b0, addr_q}) && (off < AW1'(fwd_n)))
          byte_v = wdata_q[8*off[1:0] +: 8];
        i_data[8*j +: 8] = byte_v;
      end
    end
  end

  assign d_ready = (state_q == ST_IDLE);
  assign busy    = ~d_ready;
  assign d_ack   = ack_q;
  assign d_err   = err_q;
  assign d_rdata = rdata_q;

endmodule
